// File: rtl/hex_keypad_encoder_if.sv
// rtl/hex_keypad_encoder_if.sv - key code / press strobe / held bundle toward the calculator FSM
interface hex_keypad_encoder_if;
    logic [3:0] oKEY;
    logic       oVALID;
    logic       oHELD;

    modport master (output oKEY, output oVALID, output oHELD);
    modport slave  (input  oKEY, input  oVALID, input  oHELD);
endinterface

// File: rtl/hex_keypad_encoder.sv
// rtl/hex_keypad_encoder.sv - 4x4 active-low keypad scanner, snapshot decoder and press/release debouncer
module hex_keypad_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [3:0] iROW,
    output logic [3:0] oCOL,
    hex_keypad_encoder_if.master kif
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_TARGET  = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [3:0]    samp0, samp1, samp2;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    key, key_n;
    logic          valid, valid_n;
    logic          held, held_n;

    logic          sample_now;
    logic          snap_en;
    logic [3:0]    col_rows [4];
    logic [15:0]   pressed;
    logic [4:0]    n_pressed;
    logic [3:0]    snap_code;
    logic          snap_key;

    assign sample_now = (dwell == DWELL_LAST);
    assign snap_en    = sample_now && (col == 2'd3);
    assign oCOL       = ~(4'b0001 << col);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            dwell  <= '0;
            col    <= 2'd0;
            samp0  <= 4'hF;
            samp1  <= 4'hF;
            samp2  <= 4'hF;
        end else begin
            row_s1 <= iROW;
            row_s2 <= row_s1;
            if (sample_now) begin
                dwell <= '0;
                col   <= col + 2'd1;
                case (col)
                    2'd0:    samp0 <= row_s2;
                    2'd1:    samp1 <= row_s2;
                    2'd2:    samp2 <= row_s2;
                    default: ;
                endcase
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Column 3 is taken straight from the synchronizer so the FSM can act on the sample edge itself.
    assign col_rows[0] = samp0;
    assign col_rows[1] = samp1;
    assign col_rows[2] = samp2;
    assign col_rows[3] = row_s2;

    always_comb begin
        pressed = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                pressed[4*r + c] = ~col_rows[c][r];
            end
        end
    end

    always_comb begin
        n_pressed = '0;
        snap_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                n_pressed = n_pressed + 5'd1;
                snap_code = 4'(i);
            end
        end
    end

    // Zero keys and multi-key (ghosting / rollover) both collapse to NONE.
    assign snap_key = (n_pressed == 5'd1);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
            key   <= '0;
            valid <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
            key   <= key_n;
            valid <= valid_n;
            held  <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        key_n   = key;
        valid_n = 1'b0;
        held_n  = held;
        if (snap_en) begin
            case (state)
                IDLE: begin
                    if (snap_key) begin
                        cand_n = snap_code;
                        cnt_n  = 4'd1;
                        if (DEBOUNCE == 1) begin
                            key_n   = snap_code;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = HELD;
                        end else begin
                            state_n = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (snap_key && snap_code == cand) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt + 4'd1 == DB_TARGET) begin
                            key_n   = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = HELD;
                        end
                    end else if (!snap_key) begin
                        state_n = IDLE;
                    end else begin
                        cand_n = snap_code;
                        cnt_n  = 4'd1;
                    end
                end
                HELD: begin
                    if (!(snap_key && snap_code == cand)) begin
                        cnt_n = 4'd1;
                        if (DEBOUNCE == 1) begin
                            held_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            state_n = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (snap_key && snap_code == cand) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt + 4'd1;
                        if (cnt + 4'd1 == DB_TARGET) begin
                            held_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign kif.oKEY   = key;
    assign kif.oVALID = valid;
    assign kif.oHELD  = held;
endmodule

// File: tb/tb_hex_keypad_encoder.sv
// tb/tb_hex_keypad_encoder.sv - randomized and directed bench for hex_keypad_encoder against a run-length model
module tb_hex_keypad_encoder;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [3:0]  iROW;
    logic [3:0]  oCOL;
    logic [15:0] keys = '0;

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_held;
    logic [3:0] m_key;
    int         run_len;
    int         run_code;
    int         miss;

    hex_keypad_encoder_if kif ();

    hex_keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .iROW (iROW),
        .oCOL (oCOL),
        .kif  (kif.master)
    );

    always #5 iCLK = ~iCLK;

    // Passive matrix: row r reads low when any pressed key in that row sits on the driven column.
    assign iROW = {~|(keys[15:12] & ~oCOL), ~|(keys[11:8] & ~oCOL),
                   ~|(keys[7:4]   & ~oCOL), ~|(keys[3:0]  & ~oCOL)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_held   = 1'b0;
        m_key    = 4'h0;
        run_len  = 0;
        run_code = -1;
        miss     = 0;
    endtask

    task automatic model_step(input logic [15:0] k, output bit exp_valid);
        int snap;
        snap = -1;
        if ($countones(k) == 1) begin
            for (int i = 0; i < 16; i++) if (k[i]) snap = i;
        end
        exp_valid = 1'b0;
        if (!m_held) begin
            if (snap < 0) begin
                run_len = 0;
            end else begin
                if (run_len > 0 && snap == run_code) run_len++;
                else run_len = 1;
                run_code = snap;
                if (run_len == DEBOUNCE) begin
                    m_held    = 1'b1;
                    m_key     = 4'(snap);
                    exp_valid = 1'b1;
                    miss      = 0;
                end
            end
        end else begin
            if (snap == int'(m_key)) begin
                miss = 0;
            end else begin
                miss++;
                if (miss == DEBOUNCE) begin
                    m_held  = 1'b0;
                    run_len = 0;
                end
            end
        end
    endtask

    task automatic run_scan(input logic [15:0] k, input string tag);
        bit         ev;
        int         stray;
        logic [3:0] exp_col;
        stray = 0;
        keys  = k;
        model_step(k, ev);
        for (int i = 0; i < SCAN; i++) begin
            @(posedge iCLK);
            #1;
            if (i < SCAN - 1 && kif.oVALID) stray++;
            if ((i + 1) % SCAN_DIV == 0) begin
                exp_col = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
                check({tag, " col"}, 32'(oCOL), 32'(exp_col));
            end
        end
        check({tag, " valid"}, 32'(kif.oVALID), 32'(ev));
        check({tag, " key"},   32'(kif.oKEY),   32'(m_key));
        check({tag, " held"},  32'(kif.oHELD),  32'(m_held));
        check({tag, " stray_valid"}, 32'(stray), 32'd0);
    endtask

    task automatic reset_mid(input logic [15:0] k, input int pre, input string tag);
        keys = k;
        repeat (pre) @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        model_reset();
        check({tag, " col"},   32'(oCOL),        32'h0000000E);
        check({tag, " key"},   32'(kif.oKEY),    32'h0);
        check({tag, " valid"}, 32'(kif.oVALID),  32'h0);
        check({tag, " held"},  32'(kif.oHELD),   32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] prev;
        logic [15:0] nk;
        int          sel;
        model_reset();
        repeat (3) @(posedge iCLK);
        #1;
        check("por col",   32'(oCOL),       32'h0000000E);
        check("por key",   32'(kif.oKEY),   32'h0);
        check("por valid", 32'(kif.oVALID), 32'h0);
        check("por held",  32'(kif.oHELD),  32'h0);
        iRST = 1'b0;

        run_scan(16'h0000, "idle0");
        run_scan(16'h0000, "idle1");
        reset_mid(16'h0000, 5, "rst_mid");
        run_scan(16'h0000, "walk");

        for (int s = 0; s < 5; s++) run_scan(16'h0040, "press6");
        for (int s = 0; s < 4; s++) run_scan(16'h0000, "rel6");

        for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? 16'h8000 : 16'h0000, "bounceF");
        for (int s = 0; s < 4; s++) run_scan(16'h8000, "holdF");
        for (int s = 0; s < 4; s++) run_scan(16'h0000, "relF");

        for (int s = 0; s < 4; s++) run_scan(16'h0201, "ghost");
        for (int s = 0; s < 4; s++) run_scan(16'h0001, "ghost_single0");
        for (int s = 0; s < 4; s++) run_scan(16'h0000, "rel0");

        for (int s = 0; s < 4; s++) run_scan(16'h0200, "hold9");
        run_scan(16'h0000, "glitch9");
        for (int s = 0; s < 3; s++) run_scan(16'h0200, "restore9");
        run_scan(16'h0040, "direct6a");
        run_scan(16'h0040, "direct6b");
        for (int s = 0; s < 5; s++) run_scan(16'h0040, "direct6c");
        for (int s = 0; s < 4; s++) run_scan(16'h0000, "rel_direct");

        for (int s = 0; s < 4; s++) run_scan(16'h0020, "hold5");
        reset_mid(16'h0020, 7, "rst_held");
        for (int s = 0; s < 4; s++) run_scan(16'h0020, "repress5");
        for (int s = 0; s < 4; s++) run_scan(16'h0000, "rel5");

        prev = '0;
        for (int s = 0; s < 150; s++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) nk = prev;
            else if (sel <= 6) nk = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 7) nk = '0;
            else if (sel == 8) nk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            else nk = 16'($urandom);
            prev = nk;
            run_scan(nk, "rand");
        end
        for (int s = 0; s < 4; s++) run_scan(16'h0000, "final_rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hex_keypad_encoder.md
# hex_keypad_encoder

Scans a 4x4 active-low matrix keypad and encodes each debounced key press into the 4-bit hex digit code that the calculator datapath and 7-segment display path consume. Codes 0x0–0xE are operands and operators. Code 0xF is the minus key, matching the display's minus-sign code. The block sits between the keypad pins and the calculator control FSM, and emits one single-cycle strobe per press.

## Interface
- SCAN_DIV, 1000: clocks each column is driven before advancing. Legal range ≥ 4.
- DEBOUNCE, 4: consecutive identical full-scan snapshots needed to accept a press or a release. Legal range 1–15.

- iCLK  input  1  system clock. All logic is on the rising edge.
- iRST  input  1  reset. Synchronous and active-high.
- iROW  input  4  keypad row inputs. Active-low, externally pulled up, asynchronous to iCLK.
- oCOL  output 4  keypad column drive. Active-low and one-hot-low.
- oKEY  output 4  code of the last accepted key. Held stable until the next accepted press.
- oVALID output 1  one-cycle strobe that oKEY has just been updated with a new press.
- oHELD output 1  high while the accepted key is considered held, until its release is debounced.

## Operation
- **Input sync:** iROW passes through a 2-flop synchronizer. Downstream logic uses only the synchronized value.
- **Column scan:**
  - A dwell counter counts 0..SCAN_DIV-1. At wrap, the column index advances 0→1→2→3→0.
  - oCOL drives the current column low: col0 = 4'b1110, col1 = 4'b1101, col2 = 4'b1011, col3 = 4'b0111.
- **Row sampling:**
  - The synchronized rows are sampled at dwell count SCAN_DIV-1 of each column.
  - A low row bit r in column c marks key (r,c) as pressed.
- **Snapshot:** after the column-3 sample, the four column samples form one snapshot.
  - Exactly one key pressed: snapshot = that key.
  - Zero keys, or two or more keys (ghosting or rollover): snapshot = NONE.
- **Key code:** code = 4·row + col. For example, row1 col2 = 4'h6 and row3 col3 = 4'hF (minus).
- **Debounce FSM:** evaluated once per snapshot. cnt is 4 bits; cand is the candidate code.
  - **IDLE:**
    - Snapshot is key K: cand←K, cnt←1. If DEBOUNCE=1, accept immediately; otherwise go to PRESS_DB.
    - Snapshot is NONE: stay in IDLE.
  - **PRESS_DB:**
    - Snapshot == cand: cnt++. When cnt reaches DEBOUNCE, accept and go to HELD.
    - Snapshot is NONE: go to IDLE.
    - Snapshot is a different key K': cand←K', cnt←1.
  - **Accept:** oKEY←cand, oVALID←1 for exactly one cycle, oHELD←1.
  - **HELD:**
    - Snapshot == cand: stay in HELD.
    - Anything else: cnt←1. If DEBOUNCE=1, release immediately; otherwise go to REL_DB.
  - **REL_DB:**
    - Snapshot == cand: return to HELD.
    - Snapshot ≠ cand: cnt++. When cnt reaches DEBOUNCE, release.
  - **Release:** oHELD←0, go to IDLE. oKEY keeps its value.
- **Auto-repeat:** none. A held key produces exactly one oVALID.
- **Direct key change:** going from key A to key B with no NONE in between first debounces the release of A. B is then accepted from IDLE, so it needs a further DEBOUNCE matching scans.

## Timing
- **Reset values:** oCOL = 4'b1110, oKEY = 4'h0, oVALID = 0, oHELD = 0. State = IDLE, dwell counter = 0, column = 0, cnt = 0, cand = 0, synchronizer flops = 4'hF.
- **Reset mid-operation:** all state returns to the reset values, including mid-debounce and HELD. A key still held after reset is detected as a new press and produces a new oVALID after DEBOUNCE snapshots.
- **Scan period:** 4·SCAN_DIV cycles.
- **Column timing:** a column is driven at least SCAN_DIV-1 cycles before its sample. This covers the 2-cycle synchronizer plus external settling.
- **Snapshot to FSM:** the FSM acts on a snapshot on the cycle after the column-3 sample. oVALID and oHELD change on that cycle.
- **Press latency:** the Nth matching snapshot is the first moment an accept can occur, i.e. DEBOUNCE scans after the key is first seen. Worst case from physical press to oVALID is (DEBOUNCE+1)·4·SCAN_DIV + 3 cycles.
- **Release latency:** DEBOUNCE snapshots after the first non-matching snapshot.
- **Output timing:** oKEY updates on the same edge that oVALID rises.
- **oVALID rule:** oVALID is never high on two consecutive cycles.

## Test plan
- **Reset:** assert iRST mid-scan with iROW=4'hF. Required: next cycle oCOL=4'b1110, oKEY=0, oVALID=0, oHELD=0. Then oCOL walks 1110→1101→1011→0111 every SCAN_DIV cycles.
- **Single press:** SCAN_DIV=4, DEBOUNCE=3. Pull row1 low while col2 is driven, and hold it there. Required: exactly one oVALID pulse with oKEY=4'h6 on the cycle after the third matching snapshot, and oHELD=1 from that cycle. Release the key. Required: oHELD=0 after 3 empty snapshots, and oKEY stays 6.
- **Bounce rejection:** toggle key (3,3) present/absent on alternate snapshots. Required: no oVALID. Then hold it steady. Required: one oVALID with oKEY=4'hF.
- **Ghost rejection:** hold keys (0,0) and (2,1) together. Required: no oVALID and oHELD stays 0. Release (2,1). Required: oVALID with oKEY=4'h0.
- **Release glitch:** while key 4'h9 is held, drop it for 1 snapshot (fewer than DEBOUNCE), then restore it. Required: oHELD stays 1 and no second oVALID.
- **Reset while held:** assert iRST while key 4'h5 is in HELD, and keep the key pressed. Required: outputs clear, then a fresh oVALID with oKEY=4'h5 after DEBOUNCE snapshots.
